// File: rtl/reg_char_streamer_pkg.sv
// -----------------------------------------------------------------------------
// riscv_stream_pkg
//   Shared types and constants for the register-to-character streamer.
//   - stream_state_e : controller state encoding
//   - BYTES_PER_WORD : bytes emitted per captured 32-bit register word
//   - stream_bytes() : total bytes in one stream for a given word count
// -----------------------------------------------------------------------------
package riscv_stream_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } stream_state_e;

  function automatic int stream_bytes(input int num_words);
    return num_words * BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/reg_char_streamer.sv
// -----------------------------------------------------------------------------
// reg_char_streamer
//   Captures NUM_WORDS 32-bit register words on a start request and streams
//   them out one byte per accepted handshake, most significant byte of word 0
//   first. Bytes are taken from the top of a left-shifting buffer; a
//   down-counter of remaining bytes terminates the stream.
//
//   Build option: define CHAR_STREAM_NUL_TERM_EN to end the stream at the
//   first 0x00 byte instead of presenting it. Undefined (default): every byte
//   is streamed, including 0x00.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous reset, active low
//   start      in   capture request, honoured only in IDLE
//   words      in   register words, word 0 in the top 32 bits
//   char_data  out  current character (0 when char_valid is low)
//   char_valid out  char_data holds a character
//   char_ready in   consumer accepts the character this cycle
//   busy       out  high in LOAD and SEND
//   done       out  one-cycle pulse when the stream ends
//   sent_cnt   out  characters transferred in the current or last stream
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; sent_cnt holds the last stream's count
// LOAD  | buffer just captured; one cycle before the first character
// SEND  | presenting the top buffer byte until char_ready accepts it
// DONE  | one cycle with done high, then back to IDLE
// -----------------------------------------------------------------------------
module reg_char_streamer
  import riscv_stream_pkg::*;
#(
  parameter int NUM_WORDS = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [32*NUM_WORDS-1:0]              words,
  output logic [7:0]                           char_data,
  output logic                                 char_valid,
  input  logic                                 char_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(4*NUM_WORDS+1)-1:0]     sent_cnt
);

  localparam int TOTAL = stream_bytes(NUM_WORDS);
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int BW    = 32 * NUM_WORDS;

  stream_state_e  state_q, state_d;
  logic [BW-1:0]  buf_q, buf_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic [CW-1:0]  sent_q, sent_d;
  logic [7:0]     char_data_q, char_data_d;
  logic           char_valid_q, char_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           xfer;

  // Only a presented character can be consumed; ready alone does nothing.
  assign xfer = char_valid_q && char_ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    rem_d   = rem_q;
    sent_d  = sent_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          buf_d   = words;
          rem_d   = CW'(TOTAL);
          sent_d  = '0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        state_d = ST_SEND;
`ifdef CHAR_STREAM_NUL_TERM_EN
        // A leading NUL means an empty string: skip straight to DONE.
        if (buf_q[BW-1 -: 8] == 8'h00) begin
          state_d = ST_DONE;
        end
`endif
      end

      ST_SEND: begin
        if (xfer) begin
          buf_d  = buf_q << 8;
          rem_d  = rem_q - CW'(1);
          sent_d = sent_q + CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = ST_DONE;
          end
`ifdef CHAR_STREAM_NUL_TERM_EN
          // Look one byte ahead so the NUL is never presented.
          else if (buf_q[BW-9 -: 8] == 8'h00) begin
            state_d = ST_DONE;
          end
`endif
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    char_valid_d = (state_d == ST_SEND);
    char_data_d  = char_valid_d ? buf_d[BW-1 -: 8] : 8'h00;
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_SEND);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      rem_q        <= '0;
      sent_q       <= '0;
      char_data_q  <= 8'h00;
      char_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      rem_q        <= rem_d;
      sent_q       <= sent_d;
      char_data_q  <= char_data_d;
      char_valid_q <= char_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign char_data  = char_data_q;
  assign char_valid = char_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_cnt   = sent_q;

  // Interface invariants.
  a_data_zero_when_idle : assert property (@(posedge clk) disable iff (!rst)
    !char_valid_q |-> (char_data_q == 8'h00));

  a_stall_holds : assert property (@(posedge clk) disable iff (!rst)
    (char_valid_q && !char_ready) |=> (char_valid_q && $stable(char_data_q)));

  a_done_not_busy : assert property (@(posedge clk) disable iff (!rst)
    done_q |-> (!busy_q && !char_valid_q));

endmodule

// File: tb/tb_reg_char_streamer.sv
module tb_reg_char_streamer;

  localparam int NW = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [95:0]   words;
  logic [7:0]    char_data;
  logic          char_valid;
  logic          char_ready;
  logic          busy;
  logic          done;
  logic [3:0]    sent_cnt;

  int n_cmp = 0;
  int n_err = 0;

  reg_char_streamer #(.NUM_WORDS(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .words      (words),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .done       (done),
    .sent_cnt   (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic [3:0] sent;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t tbl[15];

  logic [7:0] hello_b[12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                              8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
  logic [7:0] alt_b[12]   = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
                              8'h47, 8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C};
  logic [7:0] bye_b[12]   = '{8'h42, 8'h79, 8'h65, 8'h20, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_bytes[12];
  int         exp_len;

  localparam logic [95:0] HELLO = 96'h48656C6C_6F20576F_726C6421;
  localparam logic [95:0] ALT   = 96'h41424344_45464748_494A4B4C;
  localparam logic [95:0] BYE   = 96'h42796520_00000000_00000000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Starts a stream and follows it to done, checking every presented byte
  // against exp_bytes, data stability on stalls, and the final count.
  // mode 0: ready always 1; 1: ready 1,0,0,1 repeating;
  // 2: ready always 1 and a second start with ALT words mid-stream.
  task automatic run_stream(input string nm, input logic [95:0] w, input int mode);
    int   idx;
    logic pv;
    logic [7:0] pd;
    logic rdy;
    logic seen_done;
    logic last_xfer;
    words      = w;
    start      = 1'b1;
    char_ready = 1'b1;
    step();
    start = 1'b0;
    chk({nm, " load busy"},  {31'd0, busy}, 32'd1);
    chk({nm, " load valid"}, {31'd0, char_valid}, 32'd0);
    chk({nm, " load sent"},  {28'd0, sent_cnt}, 32'd0);
    idx = 0; pv = char_valid; pd = char_data; seen_done = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      case (mode)
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'b1;
      endcase
      if (mode == 2 && cyc == 3) begin
        start = 1'b1;
        words = ALT;
      end else begin
        start = 1'b0;
      end
      char_ready = rdy;
      step();
      last_xfer = pv && rdy;
      if (last_xfer) begin
        idx++;
      end else if (pv) begin
        chk({nm, " stall valid"}, {31'd0, char_valid}, 32'd1);
        chk({nm, " stall data"},  {24'd0, char_data}, {24'd0, pd});
      end
      if (done) begin
        seen_done = 1'b1;
        chk({nm, " done after last xfer"}, {31'd0, last_xfer || (exp_len == 0 && cyc == 0)}, 32'd1);
        break;
      end
      chk({nm, " send valid"}, {31'd0, char_valid}, 32'd1);
      if (idx < 12) chk({nm, " byte"}, {24'd0, char_data}, {24'd0, exp_bytes[idx]});
      chk({nm, " sent_cnt"}, {28'd0, sent_cnt}, idx);
      pv = char_valid; pd = char_data;
    end
    start = 1'b0;
    chk({nm, " done seen"},   {31'd0, seen_done}, 32'd1);
    chk({nm, " count"},       idx, exp_len);
    chk({nm, " done sent"},   {28'd0, sent_cnt}, exp_len);
    chk({nm, " done valid"},  {31'd0, char_valid}, 32'd0);
    chk({nm, " done busy"},   {31'd0, busy}, 32'd0);
    step();
    chk({nm, " post done"},   {31'd0, done}, 32'd0);
    chk({nm, " post busy"},   {31'd0, busy}, 32'd0);
    chk({nm, " post sent"},   {28'd0, sent_cnt}, exp_len);
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    words      = '0;
    char_ready = 1'b0;

    //           start ready valid data   sent   done busy
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0,  1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h48, 4'd0,  1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h65, 4'd1,  1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h6C, 4'd2,  1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h6C, 4'd3,  1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h6F, 4'd4,  1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h20, 4'd5,  1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h57, 4'd6,  1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h6F, 4'd7,  1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h72, 4'd8,  1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h6C, 4'd9,  1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h64, 4'd10, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h21, 4'd11, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 4'd12, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 4'd12, 1'b0, 1'b0};

    step();
    step();
    chk("reset valid", {31'd0, char_valid}, 32'd0);
    chk("reset data",  {24'd0, char_data}, 32'd0);
    chk("reset busy",  {31'd0, busy}, 32'd0);
    chk("reset done",  {31'd0, done}, 32'd0);
    chk("reset sent",  {28'd0, sent_cnt}, 32'd0);
    rst = 1'b1;
    char_ready = 1'b1;
    step();
    chk("idle ready no effect", {31'd0, char_valid}, 32'd0);

    // Basic stream, cycle-exact.
    words = HELLO;
    for (int i = 0; i < 15; i++) begin
      start      = tbl[i].start;
      char_ready = tbl[i].ready;
      step();
      chk($sformatf("tbl[%0d] valid", i), {31'd0, char_valid}, {31'd0, tbl[i].valid});
      chk($sformatf("tbl[%0d] data", i),  {24'd0, char_data},  {24'd0, tbl[i].data});
      chk($sformatf("tbl[%0d] sent", i),  {28'd0, sent_cnt},   {28'd0, tbl[i].sent});
      chk($sformatf("tbl[%0d] done", i),  {31'd0, done},       {31'd0, tbl[i].done});
      chk($sformatf("tbl[%0d] busy", i),  {31'd0, busy},       {31'd0, tbl[i].busy});
    end

    // Back-pressure.
    exp_bytes = hello_b; exp_len = 12;
    run_stream("stall", HELLO, 1);

    // Zero bytes.
    exp_bytes = bye_b;
`ifdef CHAR_STREAM_NUL_TERM_EN
    exp_len = 4;
`else
    exp_len = 12;
`endif
    run_stream("nul", BYE, 0);

    // Ignored start mid-stream, then the new words on a fresh start.
    exp_bytes = hello_b; exp_len = 12;
    run_stream("restart orig", HELLO, 2);
    exp_bytes = alt_b; exp_len = 12;
    run_stream("restart new", ALT, 0);

    // Reset mid-stream after byte 5.
    words = HELLO; start = 1'b1; char_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 30 && sent_cnt != 4'd5; i++) step();
    chk("rst pre sent", {28'd0, sent_cnt}, 32'd5);
    rst = 1'b0;
    step();
    chk("rst valid", {31'd0, char_valid}, 32'd0);
    chk("rst data",  {24'd0, char_data}, 32'd0);
    chk("rst busy",  {31'd0, busy}, 32'd0);
    chk("rst done",  {31'd0, done}, 32'd0);
    chk("rst sent",  {28'd0, sent_cnt}, 32'd0);
    rst = 1'b1;
    begin
      int seen_valid;
      seen_valid = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (char_valid || busy || done) seen_valid++;
      end
      chk("post rst quiet", seen_valid, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
